// File: rtl/uart_echo_fifo_if.sv
// Echo-path handshake bundle: receive side from uart_rx, transmit side to uart_tx.
// The slave modport is the FIFO; the master modport is the surrounding UART logic.
interface uart_echo_fifo_if #(
    parameter int unsigned PAYLOAD_BITS = 8
);
    logic                    rx_valid;
    logic [PAYLOAD_BITS-1:0] rx_data;
    logic                    rx_break;
    logic                    tx_busy;
    logic                    tx_en;
    logic [PAYLOAD_BITS-1:0] tx_data;

    modport master (
        output rx_valid, rx_data, rx_break, tx_busy,
        input  tx_en, tx_data
    );

    modport slave (
        input  rx_valid, rx_data, rx_break, tx_busy,
        output tx_en, tx_data
    );
endinterface

// File: rtl/uart_echo_fifo.sv
// Elastic byte buffer between uart_rx and uart_tx: queues received words and
// launches them one at a time, with sticky overflow and BREAK-flush flags.
module uart_echo_fifo #(
    parameter int unsigned PAYLOAD_BITS = 8,
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned BUSY_TIMEOUT = 15
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     clear,
    uart_echo_fifo_if.slave          bus,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow,
    output logic                     break_seen
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned TW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [PAYLOAD_BITS-1:0] mem [DEPTH];
    logic [AW-1:0]           wr_ptr;
    logic [AW-1:0]           rd_ptr;
    logic [TW-1:0]           timer;
    logic                    launch;
    logic                    full;
    logic                    push;
    logic                    drop;

    // A flush on this edge suppresses both the launch (pop) and any push.
    always_comb begin
        state_next = state;
        launch     = 1'b0;
        case (state)
            IDLE: begin
                if (fifo_count != '0 && !bus.tx_busy && !bus.rx_break) begin
                    launch     = 1'b1;
                    state_next = LAUNCH;
                end
            end
            LAUNCH: state_next = WAIT_BUSY;
            WAIT_BUSY: begin
                if (bus.tx_busy) begin
                    state_next = WAIT_DONE;
                end else if (timer == TW'(BUSY_TIMEOUT - 1)) begin
                    state_next = IDLE;
                end
            end
            WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        full = (fifo_count == CW'(DEPTH));
        push = bus.rx_valid && !bus.rx_break && (!full || launch);
        drop = bus.rx_valid && !bus.rx_break && full && !launch;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            timer       <= '0;
            bus.tx_en   <= 1'b0;
            bus.tx_data <= '0;
        end else begin
            state     <= state_next;
            bus.tx_en <= launch;
            if (launch) begin
                bus.tx_data <= mem[rd_ptr];
            end
            // Timer runs only while waiting for busy; any other state clears it.
            if (state == WAIT_BUSY) begin
                timer <= timer + TW'(1);
            end else begin
                timer <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.rx_data;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else if (bus.rx_break) begin
            rd_ptr     <= wr_ptr;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (launch) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, launch})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            overflow   <= 1'b0;
            break_seen <= 1'b0;
        end else begin
            if (drop) begin
                overflow <= 1'b1;
            end else if (clear) begin
                overflow <= 1'b0;
            end
            if (bus.rx_break) begin
                break_seen <= 1'b1;
            end else if (clear) begin
                break_seen <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_echo_fifo.sv
// Directed/randomised bench for uart_echo_fifo with a queue-based reference
// model and a simple transmitter model that answers tx_en with a busy window.
module tb_uart_echo_fifo;
    localparam int unsigned PAYLOAD_BITS = 8;
    localparam int unsigned DEPTH        = 16;
    localparam int unsigned BUSY_TIMEOUT = 15;
    localparam int          BUSY_LEN     = 20;

    logic                  clk = 1'b0;
    logic                  resetn;
    logic                  clear;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                  overflow;
    logic                  break_seen;

    uart_echo_fifo_if #(.PAYLOAD_BITS(PAYLOAD_BITS)) bus ();

    uart_echo_fifo #(
        .PAYLOAD_BITS(PAYLOAD_BITS),
        .DEPTH       (DEPTH),
        .BUSY_TIMEOUT(BUSY_TIMEOUT)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .clear     (clear),
        .bus       (bus),
        .fifo_count(fifo_count),
        .overflow  (overflow),
        .break_seen(break_seen)
    );

    always #5 clk = ~clk;

    int          n_assert = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          tx_count = 0;
    int          tx_cycles[$];
    logic [7:0]  fifo_q[$];
    logic        exp_ovf  = 1'b0;
    logic        prev_en  = 1'b0;
    logic [1:0]  busy_mode = 2'd0;  // 0: tied low, 1: held high, 2: answers tx_en
    int          busy_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Transmitter model: busy rises one cycle after tx_en and lasts BUSY_LEN cycles.
    always @(negedge clk) begin
        case (busy_mode)
            2'd0: begin bus.tx_busy = 1'b0; busy_cnt = 0; end
            2'd1: begin bus.tx_busy = 1'b1; busy_cnt = 0; end
            default: begin
                bus.tx_busy = (busy_cnt > 0);
                if (busy_cnt > 0) busy_cnt--;
                if (bus.tx_en) busy_cnt = BUSY_LEN;
            end
        endcase
    end

    always @(negedge clk) begin
        if (resetn) begin
            if (bus.tx_en) begin
                check("tx_en_width", prev_en, 0);
                check("tx_en_expected", fifo_q.size() != 0, 1);
                if (fifo_q.size() != 0) check("tx_data_order", bus.tx_data, fifo_q.pop_front());
                tx_count++;
                tx_cycles.push_back(cyc);
            end
            prev_en = bus.tx_en;
        end else begin
            prev_en = 1'b0;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        bus.rx_valid = 1'b1;
        bus.rx_data  = d;
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
        if (fifo_q.size() < DEPTH) fifo_q.push_back(d);
        else exp_ovf = 1'b1;
    endtask

    task automatic wait_tx(input int target, input int budget);
        int n = 0;
        while (tx_count < target && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("wait_tx", tx_count, target);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    initial begin
        int         n0;
        int         d;
        logic [7:0] w[4];

        resetn = 1'b0; clear = 1'b0;
        bus.rx_valid = 1'b0; bus.rx_data = '0; bus.rx_break = 1'b0;

        // Reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tx_en", bus.tx_en, 0);
        check("rst_tx_data", bus.tx_data, 0);
        check("rst_count", fifo_count, 0);
        check("rst_overflow", overflow, 0);
        check("rst_break", break_seen, 0);
        resetn = 1'b1;
        step(2);

        // Single echo with latency check
        busy_mode = 2'd2;
        step(1);
        push(8'h41);
        n0 = cyc;
        wait_tx(1, 20);
        if (tx_cycles.size() > 0) check("echo_latency", tx_cycles[$] - n0, 1);
        step(BUSY_LEN + 10);

        // Burst while transmitter busy
        busy_mode = 2'd1;
        step(2);
        for (int i = 1; i <= 5; i++) push(8'(i));
        @(negedge clk);
        check("burst_count", fifo_count, 5);
        busy_mode = 2'd2;
        wait_tx(6, 300);
        step(BUSY_LEN + 10);
        check("burst_drained", fifo_count, 0);

        // Overflow
        busy_mode = 2'd1;
        step(2);
        for (int i = 0; i < DEPTH + 2; i++) push(8'($urandom));
        @(negedge clk);
        check("ovf_count", fifo_count, DEPTH);
        check("ovf_flag", overflow, exp_ovf);
        pulse_clear();
        exp_ovf = 1'b0;
        @(negedge clk);
        check("ovf_cleared", overflow, exp_ovf);
        check("ovf_count_held", fifo_count, fifo_q.size());
        busy_mode = 2'd2;
        wait_tx(6 + DEPTH, 800);
        step(BUSY_LEN + 10);

        // Break with one word in flight
        busy_mode = 2'd1;
        step(2);
        for (int i = 0; i < 4; i++) begin
            w[i] = 8'($urandom);
            push(w[i]);
        end
        busy_mode = 2'd2;
        n0 = tx_count;
        wait_tx(n0 + 1, 10);
        step(3);
        bus.rx_break = 1'b1;
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'hEE;
        @(posedge clk);
        #1;
        bus.rx_break = 1'b0;
        bus.rx_valid = 1'b0;
        fifo_q.delete();
        @(negedge clk);
        check("brk_count", fifo_count, fifo_q.size());
        check("brk_flag", break_seen, 1);
        check("brk_tx_data_held", bus.tx_data, w[0]);
        repeat (60) @(negedge clk);
        check("brk_no_more_tx", tx_count, n0 + 1);
        pulse_clear();
        @(negedge clk);
        check("brk_cleared", break_seen, 0);

        // Busy timeout: tx_busy tied low
        busy_mode = 2'd0;
        step(2);
        n0 = tx_count;
        push(8'($urandom));
        push(8'($urandom));
        wait_tx(n0 + 2, 100);
        if (tx_cycles.size() >= 2) begin
            d = tx_cycles[$] - tx_cycles[$-1];
            check("timeout_spacing", (d >= BUSY_TIMEOUT + 1) && (d <= BUSY_TIMEOUT + 3), 1);
        end
        push(8'($urandom));
        wait_tx(n0 + 3, 60);
        step(BUSY_TIMEOUT + 5);
        check("final_count", fifo_count, 0);
        check("final_overflow", overflow, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
